// File: rtl/rv_pkg.sv
// Shared RV core types: data width, register count and the writeback entry carried
// through the LSU result buffer.
package rv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [4:0]      reg_idx_t;

   typedef struct packed {
      reg_idx_t rd;
      word_t    data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries (LSU result buffer).
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       enqueue push_data; honoured when not full, or when full with a pop
//   push_data  entry to enqueue
//   pop        dequeue head; ignored when empty
//   full       DEPTH entries held
//   empty      no entries held
//   head       oldest entry (valid only when !empty)
module wb_fifo
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle makes room, so a push is legal even when full.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered LSU results,
// keeps the pending-register scoreboard and bounds LSU starvation with a pipe stall.
// Optional feature macro: WB_STARVE_CNT_EN adds the stall_events counter port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data   pipeline WB result
//   pipe_stall                     pipeline must hold its result this cycle
//   lsu_valid/lsu_ready            LSU result handshake (ready = buffer not full)
//   lsu_rd/lsu_data                LSU result
//   iss_valid/iss_rd               LSU op issued; marks iss_rd pending
//   busy_mask                      registers with an undelivered LSU result
//   wb_we/wb_rd/wb_data            register-file write port
//   stall_events                   (WB_STARVE_CNT_EN only) saturating stall-cycle count
module regfile_wb_arbiter
   import rv_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_stall,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic [31:0] busy_mask,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
`ifdef WB_STARVE_CNT_EN
   ,
   output logic [31:0] stall_events
`endif
);

   localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic                fifo_full, fifo_empty;
   wb_entry_t           fifo_head;
   logic                lsu_push, pipe_wr, fifo_pop;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [31:0]         busy_q, busy_d;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (lsu_push),
      .push_data (wb_entry_t'{rd: lsu_rd, data: lsu_data}),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Handshake and write-slot selection. pipe_stall depends only on registered state.
   always_comb begin
      lsu_ready  = !rst && !fifo_full;
      // x0 results complete the handshake but are never buffered.
      lsu_push   = lsu_valid && lsu_ready && (lsu_rd != '0);
      pipe_stall = !rst && !fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT));
      pipe_wr    = !rst && pipe_valid && !pipe_stall && (pipe_rd != '0);
      fifo_pop   = !rst && !fifo_empty && !pipe_wr;
      wb_we      = pipe_wr || fifo_pop;
      wb_rd      = '0;
      wb_data    = '0;
      if (pipe_wr) begin
         wb_rd   = pipe_rd;
         wb_data = pipe_data;
      end else if (fifo_pop) begin
         wb_rd   = fifo_head.rd;
         wb_data = fifo_head.data;
      end
   end

   // Scoreboard next state: an issue to the same register wins over a drain clear.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
      if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
   end

   always_comb begin
      starve_d = '0;
      if (!fifo_empty && !fifo_pop && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         starve_q <= '0;
      end else begin
         busy_q   <= busy_d;
         starve_q <= starve_d;
      end
   end

   assign busy_mask = busy_q;

`ifdef WB_STARVE_CNT_EN
   logic [31:0] stall_events_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_events_q <= '0;
      end else if (pipe_stall && (stall_events_q != '1)) begin
         stall_events_q <= stall_events_q + 32'd1;
      end
   end

   assign stall_events = stall_events_q;
`endif

   // Issuer contract: these conditions are never produced by a correct issue stage.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(iss_valid && (iss_rd != '0) && busy_q[iss_rd]));
         assert (!(pipe_wr && busy_q[pipe_rd]));
         assert (!(lsu_push && !busy_q[lsu_rd]));
      end
   end

endmodule
